// File: rtl/mac_acc_to_signmag.sv
// mac_acc_to_signmag: two-stage pipeline converting a two's-complement MAC
// accumulator into sign / leading-one exponent / truncated normalized mantissa.
module mac_acc_to_signmag #(
  parameter int unsigned IN_WIDTH   = 24,
  parameter int unsigned MANT_WIDTH = 10,
  localparam int unsigned EXP_WIDTH = $clog2(IN_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [IN_WIDTH-1:0]   i_acc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sign,
  output logic [EXP_WIDTH-1:0]  o_exp,
  output logic [MANT_WIDTH-1:0] o_mant,
  output logic                  o_zero
);

  localparam int unsigned MANT_SHIFT = IN_WIDTH - MANT_WIDTH;

  // Stage 1 registers: sign and absolute magnitude
  logic                  r_s1_valid;
  logic                  r_s1_sign;
  logic [IN_WIDTH-1:0]   r_s1_mag;

  // Stage 2 registers drive the outputs directly
  logic                  r_s2_valid;
  logic                  r_sign;
  logic [EXP_WIDTH-1:0]  r_exp;
  logic [MANT_WIDTH-1:0] r_mant;
  logic                  r_zero;

  logic                  w_s1_load;
  logic                  w_s2_load;
  logic [IN_WIDTH-1:0]   w_mag;
  logic [EXP_WIDTH-1:0]  w_idx;
  logic                  w_found;
  logic [EXP_WIDTH-1:0]  w_shamt;
  logic [IN_WIDTH-1:0]   w_norm;
  logic [MANT_WIDTH-1:0] w_mant;

  // A stage loads when empty or when its content leaves in the same cycle
  assign w_s2_load = r_s1_valid & (~r_s2_valid | i_ready);
  assign o_ready   = ~r_s1_valid | w_s2_load;
  assign w_s1_load = i_valid & o_ready;

  // Magnitude; the most negative input maps to 2^(IN_WIDTH-1), which still fits
  assign w_mag = i_acc[IN_WIDTH-1] ? (~i_acc + IN_WIDTH'(1)) : i_acc;

  // Leading-one search over the stage-1 magnitude
  always_comb begin
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < int'(IN_WIDTH); i++) begin
      if (r_s1_mag[i]) begin
        w_idx   = EXP_WIDTH'(i);
        w_found = 1'b1;
      end
    end
  end

  // Normalize so the leading one sits at the MSB, then keep the top mantissa bits
  assign w_shamt = EXP_WIDTH'(IN_WIDTH - 1) - w_idx;
  assign w_norm  = r_s1_mag << w_shamt;
  assign w_mant  = MANT_WIDTH'(w_norm >> MANT_SHIFT);

  // Stage 1: capture sign and magnitude on input transfer
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mag   <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
        r_s1_sign  <= i_acc[IN_WIDTH-1];
        r_s1_mag   <= w_mag;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: exponent/mantissa; zero magnitude forces an all-zero, positive result
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_s2_valid <= 1'b0;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_mant     <= '0;
      r_zero     <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_sign     <= r_s1_sign & w_found;
        r_exp      <= w_found ? w_idx : '0;
        r_mant     <= w_found ? w_mant : '0;
        r_zero     <= ~w_found;
      end else if (i_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_s2_valid;
  assign o_sign  = r_sign;
  assign o_exp   = r_exp;
  assign o_mant  = r_mant;
  assign o_zero  = r_zero;

endmodule
